alu_muldiv_unit: RTL
====================

// Module: alu_muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide unit on the execute stage, beside the ALU.
//  Consumes op1 (register RD1) and op2 (ALU operand mux output: RD2 or sign-extended immediate).
//  Multi-cycle: radix-2 shift-add multiply and restoring divide, one bit per cycle.
//  Control stalls the pipeline on busy and captures result on done.
// PARAMETERS
//  DATA_WIDTH  32  operand/result width; must be even and >= 4
// PORTS
//  clk        in   1           clock; all state updates on posedge
//  rst        in   1           synchronous, active-high reset
//  start      in   1           request; accepted only when busy==0
//  flush      in   1           abort the in-flight operation (pipeline flush)
//  MulDivOp   in   3           muldiv_op_t (funct3 encoding), sampled with start
//  op1        in   DATA_WIDTH  first operand (rs1), sampled with start
//  op2        in   DATA_WIDTH  second operand (ALU operand mux output), sampled with start
//  busy       out  1           high from the cycle after acceptance until done is asserted
//  done       out  1           one-cycle pulse: result valid
//  result     out  DATA_WIDTH  result; held stable until the next accepted start
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, result=0; internal registers cleared. Reset overrides all inputs.
//  Ops: MUL=000 low word; MULH=001 s*s high; MULHSU=010 s*u high; MULHU=011 u*u high;
//       DIV=100, DIVU=101, REM=110, REMU=111. Products are 2*DATA_WIDTH wide internally.
//  FSM: IDLE -> RUN -> FIX -> DONE -> IDLE.
//   IDLE: start=1 latches op1/op2/MulDivOp, takes magnitudes of signed operands,
//         records the result sign, clears the counter. Next state is RUN, or DONE for special cases.
//   RUN: one iteration per cycle, counter 0..DATA_WIDTH-1. Enter FIX when counter==DATA_WIDTH-1.
//   FIX: two's-complement negate if the result sign is set; select low/high word or quotient/remainder.
//   DONE: done=1, busy=0; register result. Next cycle returns to IDLE.
//  Latency: start accepted in cycle 0, done high in cycle DATA_WIDTH+2 (34 at default).
//   Special cases are done in cycle 1.
//  Back-to-back: start may be asserted again in the cycle after done (IDLE).
//  Special cases (no iterations, RISC-V semantics):
//   divide by zero: DIV/DIVU -> all ones; REM/REMU -> op1.
//   signed overflow (op1=MIN_INT, op2=-1): DIV -> MIN_INT; REM -> 0.
//  Signs: quotient negative iff signs differ and divisor!=0; remainder takes the dividend's sign.
//   MULHSU treats only op1 as signed.
//  start while busy: ignored; latched operands are unaffected.
//  flush: any state -> IDLE next cycle; busy=0; no done pulse; result keeps its old value.
//   flush has priority over start in the same cycle.
//  Operand/op changes while busy: no effect (operands were latched).
// STRUCTURE
//  Package muldiv_pkg holds:
//   muldiv_op_t enum (3-bit, values above); muldiv_state_t enum {IDLE,RUN,FIX,DONE};
//   localparam MIN_INT, and is_div(op) / is_signed_a(op) / is_signed_b(op) helpers.
//  Sub-module muldiv_step: combinational, one iteration.
//   Multiply: conditional add + shift of {acc,multiplier}.
//   Divide: trial subtract + shift of {rem,quotient}.
//  The top level holds the FSM, counter, sign handling and result register.
// TESTING
//  1. MUL op1=7, op2=-3 (0xFFFFFFFD) -> done in cycle 34, result=0xFFFFFFEB; busy high in cycles 1..33.
//  2. MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE;
//     MULHSU op1=-1, op2=2 -> 0xFFFFFFFF.
//  3. DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  4. DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/-1 -> 0x80000000;
//     each has done in cycle 1.
//  5. MUL started; flush at cycle 10 -> busy=0 at cycle 11, no done, result unchanged;
//     a new start at cycle 11 completes normally.
//  6. rst at cycle 5 of a DIV -> next cycle busy=0, done=0, result=0.
//     start with different operands while busy -> ignored; original result returned.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and operand-sign helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} muldiv_state_t;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic is_div(input muldiv_op_t op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_rem(input muldiv_op_t op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  function automatic logic is_signed_a(input muldiv_op_t op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(input muldiv_op_t op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply on {acc,multiplier} or restoring divide on {rem,quotient}.
module muldiv_step #(
  parameter int W = 32
) (
  input  logic         i_div,
  input  logic [W-1:0] i_hi,
  input  logic [W-1:0] i_lo,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_hi,
  output logic [W-1:0] o_lo
);

  logic [W:0] w_sum;
  logic [W:0] w_shift;
  logic [W:0] w_diff;

  always_comb begin
    w_sum   = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_b} : '0);
    w_shift = {i_hi, i_lo[W-1]};
    w_diff  = w_shift - {1'b0, i_b};
    o_hi    = '0;
    o_lo    = '0;
    if (i_div) begin
      // remainder stays below the divisor, so bit W of the difference is a pure borrow flag
      if (!w_diff[W]) begin
        o_hi = w_diff[W-1:0];
        o_lo = {i_lo[W-2:0], 1'b1};
      end else begin
        o_hi = w_shift[W-1:0];
        o_lo = {i_lo[W-2:0], 1'b0};
      end
    end else begin
      o_hi = w_sum[W:1];
      o_lo = {w_sum[0], i_lo[W-1:1]};
    end
  end

endmodule

// File: rtl/alu_muldiv_unit.sv
// Iterative RV32M multiply/divide beside the ALU: one bit per cycle, unsigned core with sign fix-up.
module alu_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  flush,
  input  muldiv_op_t            MulDivOp,
  input  logic [DATA_WIDTH-1:0] op1,
  input  logic [DATA_WIDTH-1:0] op2,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  muldiv_state_t r_state;
  muldiv_op_t    r_op;
  logic [W-1:0]  r_hi, r_lo, r_b, r_result;
  logic [CW-1:0] r_cnt;
  logic          r_neg, r_busy, r_done;

  logic          w_sa, w_sb, w_neg, w_special;
  logic [W-1:0]  w_mag_a, w_mag_b, w_spec_val;
  logic [W-1:0]  w_step_hi, w_step_lo, w_fix;
  logic [2*W-1:0] w_prod;
  logic          w_run_div;

  always_comb begin
    w_sa       = is_signed_a(MulDivOp) && op1[W-1];
    w_sb       = is_signed_b(MulDivOp) && op2[W-1];
    w_mag_a    = w_sa ? -op1 : op1;
    w_mag_b    = w_sb ? -op2 : op2;
    // remainder follows the dividend; quotient and product follow the sign product
    w_neg      = is_rem(MulDivOp) ? w_sa : (w_sa ^ w_sb);
    w_special  = 1'b0;
    w_spec_val = '0;
    if (is_div(MulDivOp)) begin
      if (op2 == '0) begin
        w_special  = 1'b1;
        w_spec_val = is_rem(MulDivOp) ? op1 : '1;
      end else if ((MulDivOp inside {OP_DIV, OP_REM}) && op1 == MIN_VAL && op2 == '1) begin
        w_special  = 1'b1;
        w_spec_val = is_rem(MulDivOp) ? '0 : MIN_VAL;
      end
    end
  end

  assign w_run_div = is_div(r_op);

  muldiv_step #(.W(W)) u_step (
    .i_div (w_run_div),
    .i_hi  (r_hi),
    .i_lo  (r_lo),
    .i_b   (r_b),
    .o_hi  (w_step_hi),
    .o_lo  (w_step_lo)
  );

  always_comb begin
    w_prod = {r_hi, r_lo};
    if (r_neg) w_prod = -w_prod;
    w_fix = '0;
    case (r_op)
      OP_MUL:                       w_fix = w_prod[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_fix = w_prod[2*W-1:W];
      OP_DIV, OP_DIVU:              w_fix = r_neg ? -r_lo : r_lo;
      OP_REM, OP_REMU:              w_fix = r_neg ? -r_hi : r_hi;
      default:                      w_fix = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_op     <= OP_MUL;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      if (flush) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: if (start) begin
            r_op  <= MulDivOp;
            r_cnt <= '0;
            r_neg <= w_neg;
            r_hi  <= '0;
            r_lo  <= w_mag_a;
            r_b   <= w_mag_b;
            if (w_special) begin
              r_result <= w_spec_val;
              r_done   <= 1'b1;
              r_state  <= DONE;
            end else begin
              r_busy  <= 1'b1;
              r_state <= RUN;
            end
          end
          RUN: begin
            r_hi <= w_step_hi;
            r_lo <= w_step_lo;
            if (r_cnt == CW'(W-1)) r_state <= FIX;
            else                   r_cnt   <= r_cnt + 1'b1;
          end
          FIX: begin
            r_result <= w_fix;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= DONE;
          end
          DONE:    r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule
